// File: rtl/rot_pkg.sv
// Shared types and character constants for the rotation command parser.
package rot_pkg;

    // Parser / issue states
    typedef enum logic [2:0] {
        S_DIR  = 3'd0,
        S_NUM  = 3'd1,
        S_SKIP = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // ASCII characters the parser reacts to
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_NL = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    // Default amount width, used to size the command record
    localparam int AMT_W_DEF = 16;

    // One rotation command as seen by the dial datapath
    typedef struct packed {
        logic                 dir;
        logic [AMT_W_DEF-1:0] amt;
    } rot_cmd_t;

    // True for the ASCII decimal digits '0'..'9'
    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/rotation_sequencer.sv
// Parses "L<n>" / "R<n>" lines from a character stream into rotation
// commands, hands them to the datapath one at a time, and detects
// end-of-stream by input idleness so the last line can be flushed.
module rotation_sequencer
    import rot_pkg::*;
#(
    parameter int AMT_W       = 16,
    parameter int IDLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [7:0]       i_char,
    output logic             o_stall,
    output logic             o_cmd_vld,
    output logic             o_cmd_dir,
    output logic [AMT_W-1:0] o_cmd_amt,
    input  logic             i_cmd_rdy,
    output logic             o_flush,
    output logic             o_error
);

    localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [AMT_W+3:0] TEN = (AMT_W + 4)'(10);
    localparam logic [AMT_W+3:0] AMT_MAX = {4'b0000, {AMT_W{1'b1}}};

    state_t           r_state;
    logic             r_dir;
    logic [AMT_W-1:0] r_amt;
    logic             r_digits;
    logic             r_seenAny;
    logic             r_eosPending;
    logic             r_flush;
    logic             r_error;
    logic [CNT_W-1:0] r_idleCnt;

    logic             w_accept;
    logic             w_parseState;
    logic             w_idleInc;
    logic             w_timeout;
    logic             w_isDigit;
    logic             w_isDir;
    logic [AMT_W+3:0] w_digit;
    logic [AMT_W+3:0] w_prod;
    logic             w_ovf;

    // Handshake outputs decode purely from the registered state
    assign o_stall   = (r_state == S_EMIT) || (r_state == S_DONE);
    assign o_cmd_vld = (r_state == S_EMIT);
    assign o_cmd_dir = r_dir;
    assign o_cmd_amt = r_amt;
    assign o_flush   = r_flush;
    assign o_error   = r_error;

    assign w_accept     = i_vld && !o_stall;
    assign w_parseState = (r_state == S_DIR) || (r_state == S_NUM) || (r_state == S_SKIP);

    // Idle cycles only count once data has started and while parsing;
    // the timeout fires on the edge the count would reach IDLE_CYCLES
    assign w_idleInc = !i_vld && r_seenAny && w_parseState;
    assign w_timeout = w_idleInc && (r_idleCnt == CNT_W'(IDLE_CYCLES - 1));

    // Decimal accumulate in a widened intermediate so overflow is visible
    assign w_isDigit = is_digit(i_char);
    assign w_isDir   = (i_char == CH_L) || (i_char == CH_R);
    assign w_digit   = (AMT_W + 4)'(i_char[3:0]);
    assign w_prod    = ({4'b0000, r_amt} * TEN) + w_digit;
    assign w_ovf     = (w_prod > AMT_MAX);

    // Parser state machine, command hold, idle tracking and flush pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_DIR;
            r_dir        <= 1'b0;
            r_amt        <= '0;
            r_digits     <= 1'b0;
            r_seenAny    <= 1'b0;
            r_eosPending <= 1'b0;
            r_flush      <= 1'b0;
            r_error      <= 1'b0;
            r_idleCnt    <= '0;
        end else begin
            r_flush <= 1'b0;

            if (w_accept) begin
                r_seenAny <= 1'b1;
            end

            if (i_vld || w_timeout) begin
                r_idleCnt <= '0;
            end else if (w_idleInc) begin
                r_idleCnt <= r_idleCnt + CNT_W'(1);
            end

            case (r_state)
                S_DIR: begin
                    if (w_accept) begin
                        if (w_isDir) begin
                            r_dir    <= (i_char == CH_R);
                            r_amt    <= '0;
                            r_digits <= 1'b0;
                            r_state  <= S_NUM;
                        end else if ((i_char != CH_NL) && (i_char != CH_CR)) begin
                            r_error <= 1'b1;
                            r_state <= S_SKIP;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                        r_flush <= 1'b1;
                    end
                end
                S_NUM: begin
                    if (w_accept) begin
                        if (w_isDigit) begin
                            r_digits <= 1'b1;
                            if (w_ovf) begin
                                r_amt   <= {AMT_W{1'b1}};
                                r_error <= 1'b1;
                            end else begin
                                r_amt <= w_prod[AMT_W-1:0];
                            end
                        end else if (i_char == CH_NL) begin
                            if (r_digits) begin
                                r_state <= S_EMIT;
                            end else begin
                                r_error <= 1'b1;
                                r_state <= S_DIR;
                            end
                        end else if (i_char != CH_CR) begin
                            r_error <= 1'b1;
                            r_state <= S_SKIP;
                        end
                    end else if (w_timeout) begin
                        if (r_digits) begin
                            r_eosPending <= 1'b1;
                            r_state      <= S_EMIT;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                            r_flush <= 1'b1;
                        end
                    end
                end
                S_SKIP: begin
                    if (w_accept) begin
                        if (i_char == CH_NL) begin
                            r_state <= S_DIR;
                        end
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                        r_flush <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (i_cmd_rdy) begin
                        if (r_eosPending) begin
                            r_state <= S_DONE;
                            r_flush <= 1'b1;
                        end else begin
                            r_state <= S_DIR;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_DIR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotation_sequencer.sv
// Directed bench for rotation_sequencer: expected commands go into a
// scoreboard queue as lines are sent and are checked on each transfer.
module tb_rotation_sequencer;
    import rot_pkg::*;

    localparam int AMT_W = 16;

    logic             clk;
    logic             rst;
    logic             i_vld;
    logic [7:0]       i_char;
    logic             o_stall;
    logic             o_cmd_vld;
    logic             o_cmd_dir;
    logic [AMT_W-1:0] o_cmd_amt;
    logic             i_cmd_rdy;
    logic             o_flush;
    logic             o_error;

    int compared   = 0;
    int mismatched = 0;
    rot_cmd_t expQ[$];

    rotation_sequencer #(.AMT_W(AMT_W), .IDLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_vld     (i_vld),
        .i_char    (i_char),
        .o_stall   (o_stall),
        .o_cmd_vld (o_cmd_vld),
        .o_cmd_dir (o_cmd_dir),
        .o_cmd_amt (o_cmd_amt),
        .i_cmd_rdy (i_cmd_rdy),
        .o_flush   (o_flush),
        .o_error   (o_error)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and on mismatch count and report it
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present one char and hold it until the DUT accepts it
    task automatic applyStimulus(input logic [7:0] c);
        bit accepted = 0;
        i_vld  = 1'b1;
        i_char = c;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!o_stall) begin
                accepted = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!accepted) checkOutput("char_accept_timeout", 32'(accepted), 1);
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    endtask

    task automatic pushExp(input logic dir, input logic [AMT_W-1:0] amt);
        rot_cmd_t e;
        e.dir = dir;
        e.amt = amt;
        expQ.push_back(e);
    endtask

    task automatic doReset();
        rst       = 1'b0;
        i_vld     = 1'b0;
        i_char    = 8'h00;
        i_cmd_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every command transfer must match the oldest expectation
    always @(negedge clk) begin
        if (rst && o_cmd_vld && i_cmd_rdy) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_cmd", 32'(o_cmd_vld), 0);
            end else begin
                rot_cmd_t e;
                e = expQ.pop_front();
                checkOutput("cmd_dir", 32'(o_cmd_dir), 32'(e.dir));
                checkOutput("cmd_amt", 32'(o_cmd_amt), 32'(e.amt));
            end
        end
    end

    initial begin
        int n;
        int stallCnt;
        int flushCnt;

        // Reset values
        doReset();
        @(negedge clk);
        checkOutput("rst_stall", 32'(o_stall), 0);
        checkOutput("rst_cmd_vld", 32'(o_cmd_vld), 0);
        checkOutput("rst_dir", 32'(o_cmd_dir), 0);
        checkOutput("rst_amt", 32'(o_cmd_amt), 0);
        checkOutput("rst_flush", 32'(o_flush), 0);
        checkOutput("rst_error", 32'(o_error), 0);
        $display("[TB] reset values checked");

        // R48 with ready high: one cycle of valid, one stall cycle
        @(posedge clk);
        #1;
        pushExp(1'b1, 16'd48);
        sendString("R48\n");
        i_vld = 1'b0;
        @(negedge clk);
        checkOutput("r48_vld", 32'(o_cmd_vld), 1);
        checkOutput("r48_stall", 32'(o_stall), 1);
        @(negedge clk);
        checkOutput("r48_vld_drop", 32'(o_cmd_vld), 0);
        checkOutput("r48_stall_drop", 32'(o_stall), 0);
        checkOutput("r48_sb_empty", 32'(expQ.size()), 0);

        // L68 with ready low for three cycles, next char held by the source
        doReset();
        i_cmd_rdy = 1'b0;
        pushExp(1'b0, 16'd68);
        sendString("L68\n");
        i_vld  = 1'b1;
        i_char = CH_R;
        stallCnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (!o_stall) break;
            stallCnt++;
            checkOutput("l68_amt_hold", 32'(o_cmd_amt), 68);
            @(posedge clk);
            #1;
            if (c == 2) i_cmd_rdy = 1'b1;
        end
        checkOutput("l68_stall_cycles", 32'(stallCnt), 4);
        @(posedge clk);
        #1;
        pushExp(1'b1, 16'd2);
        sendString("2\n");
        i_vld = 1'b0;
        waitCycles(3);
        checkOutput("l68_sb_empty", 32'(expQ.size()), 0);

        // End-of-stream flush of an unterminated last line
        doReset();
        pushExp(1'b1, 16'd1);
        pushExp(1'b0, 16'd5);
        sendString("R1\nL5");
        i_vld = 1'b0;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (o_cmd_vld) begin
                n = c;
                break;
            end
        end
        checkOutput("eos_emit_delay", 32'(n), 5);
        @(negedge clk);
        checkOutput("eos_flush", 32'(o_flush), 1);
        checkOutput("eos_stall", 32'(o_stall), 1);
        flushCnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (o_flush) flushCnt++;
        end
        checkOutput("eos_flush_once", 32'(flushCnt), 0);
        checkOutput("eos_stall_held", 32'(o_stall), 1);
        checkOutput("eos_error", 32'(o_error), 0);
        checkOutput("eos_sb_empty", 32'(expQ.size()), 0);

        // Bad line skipped, CR ignored
        doReset();
        pushExp(1'b1, 16'd3);
        sendString("X12\nR3\r\n");
        i_vld = 1'b0;
        waitCycles(3);
        checkOutput("skip_error", 32'(o_error), 1);
        checkOutput("skip_sb_empty", 32'(expQ.size()), 0);

        // Overflow saturates the amount
        doReset();
        pushExp(1'b1, 16'hFFFF);
        sendString("R70000\n");
        i_vld = 1'b0;
        waitCycles(3);
        checkOutput("ovf_error", 32'(o_error), 1);
        checkOutput("ovf_sb_empty", 32'(expQ.size()), 0);

        // Reset while a command is pending drops it
        doReset();
        i_cmd_rdy = 1'b0;
        sendString("R9\n");
        i_vld = 1'b0;
        @(negedge clk);
        checkOutput("rstemit_vld_before", 32'(o_cmd_vld), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstemit_vld_after", 32'(o_cmd_vld), 0);
        checkOutput("rstemit_amt_after", 32'(o_cmd_amt), 0);
        @(posedge clk);
        #1;
        i_cmd_rdy = 1'b1;
        pushExp(1'b1, 16'd7);
        sendString("R7\n");
        i_vld = 1'b0;
        waitCycles(3);
        checkOutput("rstemit_error", 32'(o_error), 0);
        checkOutput("rstemit_sb_empty", 32'(expQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
